stepper_move_ctrl: RTL and testbench

- Single-axis step/direction sequencer between the processor's motion registers and the stepper driver pins.
- Accepts a relative move command: signed step count plus step period in clock cycles.
- Generates a direction level and timed step pulses, tracks absolute position, and reports completion.
- One instance is used per axis (X, Y).

---
 rtl/stepper_move_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_stepper_move_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_move_ctrl
//
// Single-axis step/direction sequencer. Takes a relative move (signed step
// count plus step period in clock cycles) and drives the direction level and
// timed step pulses of a stepper driver. It also tracks absolute position and
// reports completion. One instance is used per axis.
//
// Optional feature: define STEP_RAMP_EN to enable acceleration ramping. The
// step period starts at max(START_PERIOD, effective period) and drops by
// RAMP_DEC after every step, saturating at the effective period. Without the
// macro the period is constant and START_PERIOD/RAMP_DEC have no effect.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high reset
//   cmd_valid   move command present
//   cmd_ready   high only in IDLE; a move is accepted on valid & ready
//   cmd_steps   signed relative step count; the sign selects the direction
//   cmd_period  unsigned step period in cycles (clamped to PULSE_WIDTH+1)
//   abort       stop the current move (a running pulse is never cut short)
//   pos_load    load position from pos_in (IDLE only)
//   pos_in      signed position load value
//   step_out    step pulse to the driver
//   dir_out     1 = negative direction, 0 = positive
//   busy        high in every state except IDLE
//   done        one-cycle pulse at the end of every accepted move
//   aborted     qualifies done: 1 if the move ended by abort
//   position    signed absolute position (wraps modulo 2^32)
//   remaining   unsigned steps left in the current move
// -----------------------------------------------------------------------------
module stepper_move_ctrl #(
    parameter int PULSE_WIDTH  = 200,
    parameter int DIR_SETUP    = 100,
    parameter int START_PERIOD = 50000,
    parameter int RAMP_DEC     = 500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_steps,
    input  logic [31:0] cmd_period,
    input  logic        abort,
    input  logic        pos_load,
    input  logic [31:0] pos_in,
    output logic        step_out,
    output logic        dir_out,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [31:0] position,
    output logic [31:0] remaining
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [31:0] MIN_PERIOD = 32'(PULSE_WIDTH + 1);
    localparam logic [31:0] HI_LAST    = 32'(PULSE_WIDTH - 1);
    localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP - 1);
    localparam logic [31:0] RAMP_START = 32'(START_PERIOD);
    localparam logic [31:0] RAMP_STEP  = 32'(RAMP_DEC);

`ifdef STEP_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    logic [2:0]  state;
    logic [31:0] cnt;          // cycles in SETUP, or cycles since the last rise
    logic [31:0] period_min;   // effective commanded period (ramp floor)
    logic [31:0] period_cur;   // period of the step interval now running
    logic        abort_seen;   // move ends (or will end) by abort

    logic [31:0] cmd_mag;
    logic [31:0] eff_period;
    logic [31:0] start_period;
    logic [31:0] ramp_next;
    logic [31:0] pos_step;
    logic        last_end;
    logic        period_end;

    always_comb begin
        // Two's-complement magnitude; -2^31 maps to 2^31 as an unsigned count.
        cmd_mag    = cmd_steps[31] ? (~cmd_steps + 32'd1) : cmd_steps;
        eff_period = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;

        start_period = eff_period;
        if (RAMP_ON && (RAMP_START > eff_period))
            start_period = RAMP_START;

        // period_cur never drops below period_min, so the subtraction is safe.
        ramp_next = period_cur;
        if (RAMP_ON)
            ramp_next = ((period_cur - period_min) > RAMP_STEP) ?
                        (period_cur - RAMP_STEP) : period_min;

        pos_step = dir_out ? (position - 32'd1) : (position + 32'd1);

        // The DONE cycle occupies the final cycle of the last step period, so
        // the last interval leaves one cycle early. For a regular interval the
        // next rise follows the last counted cycle.
        last_end   = (remaining == 32'd0) && (cnt == (period_cur - 32'd2));
        period_end = (cnt == (period_cur - 32'd1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 32'd0;
            period_min <= 32'd0;
            period_cur <= 32'd0;
            abort_seen <= 1'b0;
            dir_out    <= 1'b0;
            position   <= 32'd0;
            remaining  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pos_load)
                        position <= pos_in;
                    if (cmd_valid) begin
                        dir_out    <= cmd_steps[31];
                        remaining  <= cmd_mag;
                        period_min <= eff_period;
                        period_cur <= start_period;
                        abort_seen <= 1'b0;
                        cnt        <= 32'd0;
                        state      <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (abort) begin
                        abort_seen <= 1'b1;
                        state      <= S_DONE;
                    end else if (cnt == SETUP_LAST) begin
                        cnt <= 32'd0;
                        if (remaining == 32'd0) begin
                            state <= S_DONE;
                        end else begin
                            // Position and count update on the rising cycle.
                            position  <= pos_step;
                            remaining <= remaining - 32'd1;
                            state     <= S_HI;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_HI: begin
                    if (cnt == HI_LAST) begin
                        if (abort_seen || abort) begin
                            abort_seen <= 1'b1;
                            state      <= S_DONE;
                        end else if (last_end) begin
                            // Period of PULSE_WIDTH+1: no low time is left.
                            state <= S_DONE;
                        end else begin
                            cnt   <= cnt + 32'd1;
                            state <= S_LO;
                        end
                    end else begin
                        // An abort is remembered so the pulse runs full width.
                        if (abort)
                            abort_seen <= 1'b1;
                        cnt <= cnt + 32'd1;
                    end
                end

                S_LO: begin
                    if (abort) begin
                        abort_seen <= 1'b1;
                        state      <= S_DONE;
                    end else if (last_end) begin
                        state <= S_DONE;
                    end else if ((remaining != 32'd0) && period_end) begin
                        cnt        <= 32'd0;
                        position   <= pos_step;
                        remaining  <= remaining - 32'd1;
                        period_cur <= ramp_next;
                        state      <= S_HI;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs are gated by reset so a reset drops the pulse and
    // suppresses any done in the same cycle, not one edge later.
    always_comb begin
        step_out  = (state == S_HI)   && !reset;
        cmd_ready = (state == S_IDLE) && !reset;
        busy      = (state != S_IDLE) && !reset;
        done      = (state == S_DONE) && !reset;
        aborted   = done && abort_seen;
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
module tb_stepper_move_ctrl;

    localparam int PW = 2;
    localparam int DS = 3;
    localparam int SP = 40;
    localparam int RD = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic [31:0] cmd_period;
    logic        abort;
    logic        pos_load;
    logic [31:0] pos_in;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] position;
    logic [31:0] remaining;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [31:0] m_pos;

    stepper_move_ctrl #(
        .PULSE_WIDTH (PW),
        .DIR_SETUP   (DS),
        .START_PERIOD(SP),
        .RAMP_DEC    (RD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .abort     (abort),
        .pos_load  (pos_load),
        .pos_in    (pos_in),
        .step_out  (step_out),
        .dir_out   (dir_out),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .position  (position),
        .remaining (remaining)
    );

    always #5 clock = ~clock;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Reference model: rise times come from summing the per-step periods, the
    // end cycle from the last rise plus its period (the DONE cycle is the last
    // cycle of that period). Cycle k is the k-th cycle after the accept edge.
    // abort_at < 0 aborts in SETUP; abort_at = a > 0 aborts during the a-th
    // pulse, or in the low time right after it when abort_lo is set.
    task automatic run_move(input int steps, input int period, input int abort_at,
                            input bit abort_lo, input bit load,
                            input logic [31:0] load_val, input string tag);
        int mag, eff, top, n_r, done_k, abort_k;
        int rises[$];
        int pers[$];
        bit ab, neg;
        logic [31:0] start_pos;

        neg = steps < 0;
        mag = neg ? -steps : steps;
        eff = (period > PW) ? period : PW + 1;
        top = eff;
`ifdef STEP_RAMP_EN
        if (SP > top) top = SP;
`endif
        for (int i = 0; i < mag; i++) begin
            int p;
            p = top;
`ifdef STEP_RAMP_EN
            p = top - i * RD;
            if (p < eff) p = eff;
`endif
            pers.push_back(p);
            rises.push_back((i == 0) ? 1 + DS : rises[i-1] + pers[i-1]);
        end

        ab      = (abort_at < 0) || ((abort_at > 0) && (abort_at <= mag));
        abort_k = 0;
        if (abort_at < 0) begin
            n_r     = 0;
            abort_k = 1;
            done_k  = 2;
        end else if (ab) begin
            n_r     = abort_at;
            abort_k = abort_lo ? rises[abort_at-1] + PW : rises[abort_at-1];
            done_k  = abort_lo ? abort_k + 1 : rises[abort_at-1] + PW;
        end else begin
            n_r    = mag;
            done_k = (mag == 0) ? DS + 1 : rises[mag-1] + pers[mag-1] - 1;
        end

        start_pos = load ? load_val : m_pos;
        check1({tag, ".ready_pre"}, cmd_ready, 1'b1);
        cmd_valid  = 1'b1;
        cmd_steps  = 32'(steps);
        cmd_period = 32'(period);
        pos_load   = load;
        pos_in     = load_val;
        @(posedge clock);

        for (int k = 1; k <= done_k + 1; k++) begin
            int seen;
            bit hi;
            @(negedge clock);
            seen = 0;
            hi   = 1'b0;
            for (int i = 0; i < n_r; i++) begin
                if (rises[i] <= k) seen++;
                if ((rises[i] <= k) && (k < rises[i] + PW)) hi = 1'b1;
            end
            check1 ({tag, ".step"},    step_out, hi);
            check1 ({tag, ".done"},    done,     k == done_k);
            check1 ({tag, ".aborted"}, aborted,  (k == done_k) && ab);
            check1 ({tag, ".busy"},    busy,     k <= done_k);
            check1 ({tag, ".ready"},   cmd_ready, k > done_k);
            check1 ({tag, ".dir"},     dir_out,  neg);
            check32({tag, ".pos"},     position,
                    neg ? start_pos - 32'(seen) : start_pos + 32'(seen));
            check32({tag, ".rem"},     remaining, 32'(mag - seen));

            abort = (k == abort_k);
            if (k <= done_k) begin
                // Command/load traffic while busy must be ignored.
                cmd_valid  = 1'($urandom_range(0, 1));
                cmd_steps  = $urandom;
                cmd_period = 32'($urandom_range(0, 4));
                pos_load   = 1'($urandom_range(0, 1));
                pos_in     = $urandom;
            end else begin
                cmd_valid = 1'b0;
                pos_load  = 1'b0;
            end
        end
        m_pos = neg ? start_pos - 32'(n_r) : start_pos + 32'(n_r);
    endtask

    initial begin
        int dones;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        pos_load   = 1'b0;
        cmd_steps  = 32'd0;
        cmd_period = 32'd0;
        pos_in     = 32'd0;
        m_pos      = 32'd0;

        repeat (2) @(negedge clock);
        check1 ("rst.step",    step_out,  1'b0);
        check1 ("rst.dir",     dir_out,   1'b0);
        check1 ("rst.busy",    busy,      1'b0);
        check1 ("rst.done",    done,      1'b0);
        check1 ("rst.aborted", aborted,   1'b0);
        check1 ("rst.ready",   cmd_ready, 1'b0);
        check32("rst.pos",     position,  32'd0);
        check32("rst.rem",     remaining, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check1("idle.ready", cmd_ready, 1'b1);

        run_move(5, 10, 0, 1'b0, 1'b0, 32'd0, "basic");
        run_move(-3, 1, 0, 1'b0, 1'b1, 32'd0, "neg_clamp");

        pos_load = 1'b1;
        pos_in   = 32'h7FFF_FFFF;
        @(negedge clock);
        pos_load = 1'b0;
        check32("load.pos", position, 32'h7FFF_FFFF);
        m_pos = 32'h7FFF_FFFF;
        run_move(2, 10, 0, 1'b0, 1'b0, 32'd0, "wrap");
        check32("wrap.final", position, 32'h8000_0001);
        run_move(0, 7, 0, 1'b0, 1'b0, 32'd0, "zero");
        run_move(1, 4, 0, 1'b0, 1'b1, 32'h0000_1234, "load_accept");

        run_move(100, 10, 4, 1'b0, 1'b0, 32'd0, "abort_hi");
        check32("abort_hi.rem", remaining, 32'd96);
        run_move(6, 8, 2, 1'b1, 1'b0, 32'd0, "abort_lo");
        run_move(-4, 6, -1, 1'b0, 1'b0, 32'd0, "abort_setup");

        for (int t = 0; t < 6; t++) begin
            int s, p;
            s = $urandom_range(0, 12) - 6;
            p = $urandom_range(0, 12);
            run_move(s, p, 0, 1'b0, 1'($urandom_range(0, 1)), $urandom, "rand");
        end

`ifdef STEP_RAMP_EN
        run_move(5, 15, 0, 1'b0, 1'b0, 32'd0, "ramp");
`endif

        // Reset in the middle of a pulse.
        cmd_valid  = 1'b1;
        cmd_steps  = 32'(-100);
        cmd_period = 32'd10;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (13) @(negedge clock);
        check1 ("mid.step_hi", step_out, 1'b1);
        check32("mid.pos",     position, m_pos - 32'd2);
        reset = 1'b1;
        #1;
        check1("mid.step_drop", step_out,  1'b0);
        check1("mid.busy",      busy,      1'b0);
        check1("mid.ready",     cmd_ready, 1'b0);
        @(negedge clock);
        check32("mid.pos_rst", position,  32'd0);
        check32("mid.rem_rst", remaining, 32'd0);
        check1 ("mid.dir_rst", dir_out,   1'b0);
        reset = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge clock);
            if (done || step_out) dones++;
        end
        check32("mid.no_done", 32'(dones), 32'd0);
        check1 ("mid.idle",    cmd_ready,  1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
